// File: rtl/mtl_bus_pkg.sv
// ============================================================================
// Module  : mtl_bus_pkg
// Purpose : Shared types and constants for the MTL-1 6809 bus-cycle logic.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mtl_bus_pkg;

    localparam int MAX_REGIONS  = 8;
    localparam int REGION_IDX_W = $clog2(MAX_REGIONS);
    localparam int DATA_W       = 8;
    localparam int ADDR_W       = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACCESS   = 2'd1,
        COMPLETE = 2'd2
    } bus_state_t;

endpackage

`default_nettype wire

// File: rtl/e_edge_sync.sv
// ============================================================================
// Module  : e_edge_sync
// Purpose : Synchronises the 6809 E clock and emits single-clock edge pulses.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module e_edge_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic e_async,
    output logic e_rise,
    output logic e_fall
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], e_async};
            r_prev <= r_sync[STAGES-1];
        end
    end

    assign e_rise =  r_sync[STAGES-1] & ~r_prev;
    assign e_fall = ~r_sync[STAGES-1] &  r_prev;

endmodule

`default_nettype wire

// File: rtl/mtl_bus_cycle_ctrl.sv
// ============================================================================
// Module  : mtl_bus_cycle_ctrl
// Purpose : 6809 E-cycle sequencer with region decode, wait/handshake stretch
//           and data steering. Optional BUS_TIMEOUT_EN adds a stretch limit.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mtl_bus_cycle_ctrl
    import mtl_bus_pkg::*;
#(
    parameter int                           N_REGIONS      = 4,
    parameter logic [ADDR_W*N_REGIONS-1:0]  REGION_BASE    = {16'hF000, 16'hA000, 16'h1000, 16'h0000},
    parameter logic [ADDR_W*N_REGIONS-1:0]  REGION_MASK    = {16'hF000, 16'hE000, 16'hF000, 16'hF000},
    parameter logic [8*N_REGIONS-1:0]       REGION_WAIT    = {8'd0, 8'd2, 8'd0, 8'd1},
    parameter logic [N_REGIONS-1:0]         REGION_HS      = 4'b1000,
    parameter int                           E_SYNC_STAGES  = 2,
    parameter int                           TIMEOUT_CYCLES = 4096
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [ADDR_W-1:0]           i_ADDRESS_BUS,
    input  logic                        i_RW,
    input  logic                        i_E,
    input  logic [DATA_W-1:0]           i_DATA_IN,
    output logic [DATA_W-1:0]           o_DATA_OUT,
    output logic                        o_DATA_OE,
    output logic                        o_MRDY,
    output logic                        o_DBEN,
    output logic [N_REGIONS-1:0]        o_region_sel,
    output logic [N_REGIONS-1:0]        o_rd_req,
    input  logic [DATA_W*N_REGIONS-1:0] i_rd_data,
    input  logic [N_REGIONS-1:0]        i_rd_valid,
    output logic [N_REGIONS-1:0]        o_wr_strobe,
    output logic [DATA_W-1:0]           o_wr_data,
    output logic                        o_error
);

    bus_state_t             r_state, w_state_nxt;
    logic [N_REGIONS-1:0]   r_region_sel, r_rd_req, r_wr_strobe;
    logic [7:0]             r_wcnt;
    logic                   r_rw, r_got_valid, r_oe;
    logic [DATA_W-1:0]      r_data_out, r_wr_data;

    logic                   w_e_rise, w_e_fall;
    logic [N_REGIONS-1:0]   w_match, w_hit_oh;
    logic                   w_hit, w_sel_hs, w_rd_valid_sel, w_hs_pending, w_stall, w_timeout;
    logic [7:0]             w_wait_acc [N_REGIONS+1];
    logic [DATA_W-1:0]      w_rdat_acc [N_REGIONS+1];
    logic                   unused_pkg;

    assign unused_pkg = ^{MAX_REGIONS, REGION_IDX_W};

    e_edge_sync #(.STAGES(E_SYNC_STAGES)) u_e_sync (
        .clk     (clk),
        .reset   (reset),
        .e_async (i_E),
        .e_rise  (w_e_rise),
        .e_fall  (w_e_fall)
    );

    // Lowest-numbered matching region wins: isolate the lowest set match bit.
    assign w_hit_oh      = w_match & (~w_match + 1'b1);
    assign w_hit         = |w_match;
    assign w_wait_acc[0] = 8'd0;
    assign w_rdat_acc[0] = '0;

    for (genvar k = 0; k < N_REGIONS; k++) begin : g_region
        assign w_match[k]      = (i_ADDRESS_BUS & REGION_MASK[ADDR_W*k +: ADDR_W]) ==
                                 REGION_BASE[ADDR_W*k +: ADDR_W];
        assign w_wait_acc[k+1] = w_wait_acc[k] | (w_hit_oh[k] ? REGION_WAIT[8*k +: 8] : 8'd0);
        assign w_rdat_acc[k+1] = w_rdat_acc[k] |
                                 (r_region_sel[k] ? i_rd_data[DATA_W*k +: DATA_W] : '0);
    end

    // A valid arriving this clock releases MRDY immediately, not one clock late.
    assign w_sel_hs       = |(REGION_HS & r_region_sel);
    assign w_rd_valid_sel = |(i_rd_valid & r_region_sel);
    assign w_hs_pending   = w_sel_hs & r_rw & ~(r_got_valid | w_rd_valid_sel);
    assign w_stall        = (r_state == ACCESS) && ((r_wcnt != 8'd0) || w_hs_pending);

`ifdef BUS_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] r_stretch;
    logic            r_error;

    assign w_timeout = w_stall && (r_stretch == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stretch <= '0;
            r_error   <= 1'b0;
        end else begin
            if (w_stall && !w_timeout) r_stretch <= r_stretch + 1'b1;
            else                       r_stretch <= '0;
            if (w_timeout)             r_error   <= 1'b1;
        end
    end

    assign o_error = r_error;
`else
    logic unused_timeout;

    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign w_timeout      = 1'b0;
    assign o_error        = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:     if (w_e_rise && w_hit)         w_state_nxt = ACCESS;
            ACCESS:   if (w_e_fall)                  w_state_nxt = IDLE;
                      else if (!w_stall || w_timeout) w_state_nxt = COMPLETE;
            COMPLETE: if (w_e_fall)                  w_state_nxt = IDLE;
            default:                                 w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_region_sel <= '0;
            r_rd_req     <= '0;
            r_wr_strobe  <= '0;
            r_wcnt       <= 8'd0;
            r_rw         <= 1'b0;
            r_got_valid  <= 1'b0;
            r_oe         <= 1'b0;
            r_data_out   <= '0;
            r_wr_data    <= '0;
        end else begin
            r_rd_req    <= '0;
            r_wr_strobe <= '0;
            case (r_state)
                IDLE: begin
                    if (w_e_rise && w_hit) begin
                        r_region_sel <= w_hit_oh;
                        r_rw         <= i_RW;
                        r_wcnt       <= w_wait_acc[N_REGIONS];
                        r_got_valid  <= 1'b0;
                        if (i_RW) r_rd_req <= w_hit_oh;
                    end
                end
                ACCESS: begin
                    if (r_wcnt != 8'd0) r_wcnt <= r_wcnt - 8'd1;
                    if (r_rw && w_rd_valid_sel && !r_got_valid) begin
                        r_got_valid <= 1'b1;
                        r_data_out  <= w_rdat_acc[N_REGIONS];
                    end
                    if (w_e_fall) begin
                        r_region_sel <= '0;
                    end else if (w_state_nxt == COMPLETE) begin
                        if (r_rw) begin
                            r_oe <= 1'b1;
                            if (w_timeout)     r_data_out <= 8'hFF;
                            else if (!w_sel_hs) r_data_out <= w_rdat_acc[N_REGIONS];
                        end else begin
                            r_wr_data   <= i_DATA_IN;
                            r_wr_strobe <= r_region_sel;
                        end
                    end
                end
                COMPLETE: begin
                    if (w_e_fall) begin
                        r_oe         <= 1'b0;
                        r_region_sel <= '0;
                    end
                end
                default: r_region_sel <= '0;
            endcase
        end
    end

    assign o_MRDY       = ~w_stall;
    assign o_DBEN       = (r_state == IDLE);
    assign o_DATA_OE    = r_oe;
    assign o_DATA_OUT   = r_data_out;
    assign o_region_sel = r_region_sel;
    assign o_rd_req     = r_rd_req;
    assign o_wr_strobe  = r_wr_strobe;
    assign o_wr_data    = r_wr_data;

endmodule

`default_nettype wire

// File: tb/tb_mtl_bus_cycle_ctrl.sv
// ============================================================================
// Module  : tb_mtl_bus_cycle_ctrl
// Purpose : Directed self-checking bench for mtl_bus_cycle_ctrl.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mtl_bus_cycle_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] addr;
    logic        rw;
    logic        e;
    logic [7:0]  din;
    logic [31:0] rd_data;
    logic [3:0]  rd_valid;
    logic [7:0]  data_out, wr_data;
    logic        data_oe, mrdy, dben, err;
    logic [3:0]  region_sel, rd_req, wr_strobe;

    int n_checks = 0;
    int n_fail   = 0;
    int low_cnt;

    mtl_bus_cycle_ctrl #(.TIMEOUT_CYCLES(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .i_ADDRESS_BUS (addr),
        .i_RW          (rw),
        .i_E           (e),
        .i_DATA_IN     (din),
        .o_DATA_OUT    (data_out),
        .o_DATA_OE     (data_oe),
        .o_MRDY        (mrdy),
        .o_DBEN        (dben),
        .o_region_sel  (region_sel),
        .o_rd_req      (rd_req),
        .i_rd_data     (rd_data),
        .i_rd_valid    (rd_valid),
        .o_wr_strobe   (wr_strobe),
        .o_wr_data     (wr_data),
        .o_error       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // E edge takes two sync flops plus one FSM clock to show on the outputs.
    task automatic raise_e();
        e = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic drop_e(input string tag, input logic oe_hold);
        e = 1'b0;
        repeat (2) @(negedge clk);
        check({tag, "_hold_oe"}, {31'd0, data_oe}, {31'd0, oe_hold});
        @(negedge clk);
        check({tag, "_idle"}, {25'd0, region_sel, dben, data_oe, mrdy}, {25'd0, 4'b0000, 1'b1, 1'b0, 1'b1});
        @(negedge clk);
    endtask

    initial begin
        reset    = 1'b1;
        addr     = 16'h0000;
        rw       = 1'b1;
        e        = 1'b0;
        din      = 8'h00;
        rd_data  = {8'hA7, 8'h3C, 8'h11, 8'h5A};
        rd_valid = 4'b0000;
        repeat (4) @(negedge clk);
        check("reset_ctl", {20'd0, region_sel, rd_req, wr_strobe}, 32'd0);
        check("reset_pins", {26'd0, mrdy, dben, data_oe, err, 2'b00}, {26'd0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00});
        check("reset_data", {16'd0, data_out, wr_data}, 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Read 0x0010, region 0, one wait state
        addr = 16'h0010; rw = 1'b1;
        raise_e();
        check("r0_access", {21'd0, region_sel, rd_req, mrdy, dben, data_oe}, {21'd0, 4'b0001, 4'b0001, 1'b0, 1'b0, 1'b0});
        @(negedge clk);
        check("r0_wait_done", {25'd0, rd_req, mrdy, data_oe}, {25'd0, 4'b0000, 1'b1, 1'b0});
        @(negedge clk);
        check("r0_drive", {22'd0, data_oe, mrdy, data_out}, {22'd0, 1'b1, 1'b1, 8'h5A});
        drop_e("r0", 1'b1);

        // Write 0x1234 = C3, region 1, no waits; address changes mid-cycle
        addr = 16'h1234; rw = 1'b0; din = 8'hC3;
        raise_e();
        check("w1_access", {20'd0, region_sel, wr_strobe, 1'b0, mrdy, dben, rd_req[0]}, {20'd0, 4'b0010, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0});
        addr = 16'h9000;
        @(negedge clk);
        check("w1_strobe", {19'd0, wr_strobe, mrdy, wr_data}, {19'd0, 4'b0010, 1'b1, 8'hC3});
        din = 8'h00;
        @(negedge clk);
        check("w1_strobe_end", {27'd0, wr_strobe, mrdy}, {27'd0, 4'b0000, 1'b1});
        drop_e("w1", 1'b0);

        // Read 0xA005, region 2, two wait states
        addr = 16'hA005; rw = 1'b1;
        raise_e();
        check("r2_c0", {27'd0, region_sel, mrdy}, {27'd0, 4'b0100, 1'b0});
        @(negedge clk);
        check("r2_c1", {31'd0, mrdy}, 32'd0);
        @(negedge clk);
        check("r2_c2", {30'd0, mrdy, data_oe}, {30'd0, 1'b1, 1'b0});
        @(negedge clk);
        check("r2_drive", {23'd0, data_oe, data_out}, {23'd0, 1'b1, 8'h3C});
        drop_e("r2", 1'b1);

        // Write to region 2 aborted by E falling during the wait states
        addr = 16'hA000; rw = 1'b0; din = 8'h55;
        raise_e();
        e = 1'b0;
        @(negedge clk);
        check("abort_c1", {27'd0, wr_strobe, mrdy}, {27'd0, 4'b0000, 1'b0});
        @(negedge clk);
        check("abort_c2", {26'd0, wr_strobe, mrdy, dben}, {26'd0, 4'b0000, 1'b1, 1'b0});
        @(negedge clk);
        check("abort_idle", {16'd0, region_sel, wr_strobe, dben, data_oe, 2'b00, wr_data}, {16'd0, 4'b0000, 4'b0000, 1'b1, 1'b0, 2'b00, 8'hC3});
        @(negedge clk);

        // Handshake read 0xF800, valid 20 clocks after rd_req; stray valid on region 0
        addr = 16'hF800; rw = 1'b1;
        raise_e();
        check("hs_access", {24'd0, region_sel, rd_req}, {24'd0, 4'b1000, 4'b1000});
        low_cnt = mrdy ? 0 : 1;
        for (int i = 1; i < 20; i++) begin
            @(negedge clk);
            if (i == 5) rd_valid = 4'b0001;
            if (i == 6) rd_valid = 4'b0000;
            #1;
            if (i == 5) check("hs_stray_valid", {31'd0, mrdy}, 32'd0);
            if (!mrdy) low_cnt++;
        end
        @(negedge clk);
        rd_valid = 4'b1000;
        #1;
        check("hs_low_clocks", low_cnt, 32'd20);
        check("hs_release", {31'd0, mrdy}, 32'd1);
        @(negedge clk);
        rd_valid = 4'b0000;
        check("hs_drive", {22'd0, data_oe, mrdy, data_out}, {22'd0, 1'b1, 1'b1, 8'hA7});
        drop_e("hs", 1'b1);

        // Unmapped 0x9000: nothing happens for the whole E cycle
        addr = 16'h9000; rw = 1'b1;
        e = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("nomap_high", {21'd0, region_sel, rd_req, dben, mrdy, data_oe}, {21'd0, 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0});
        end
        e = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("nomap_low", {21'd0, region_sel, rd_req, dben, mrdy, data_oe}, {21'd0, 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0});
        end

        // Reset while an HS read is stalled
        addr = 16'hF800; rw = 1'b1;
        raise_e();
        @(negedge clk);
        check("rst_pre_stall", {31'd0, mrdy}, 32'd0);
        reset = 1'b1;
        e     = 1'b0;
        @(negedge clk);
        check("rst_mid_ctl", {20'd0, region_sel, rd_req, wr_strobe}, 32'd0);
        check("rst_mid_pins", {28'd0, mrdy, dben, data_oe, err}, {28'd0, 1'b1, 1'b1, 1'b0, 1'b0});
        check("rst_mid_data", {16'd0, data_out, wr_data}, 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        addr = 16'h0010;
        raise_e();
        check("post_rst_access", {24'd0, region_sel, rd_req}, {24'd0, 4'b0001, 4'b0001});
        repeat (2) @(negedge clk);
        check("post_rst_drive", {23'd0, data_oe, data_out}, {23'd0, 1'b1, 8'h5A});
        drop_e("post_rst", 1'b1);

`ifdef BUS_TIMEOUT_EN
        // HS read with no valid: released after 16 stretched clocks
        addr = 16'hF800; rw = 1'b1;
        raise_e();
        low_cnt = mrdy ? 0 : 1;
        for (int i = 1; i < 16; i++) begin
            @(negedge clk);
            if (!mrdy) low_cnt++;
        end
        @(negedge clk);
        check("to_low_clocks", low_cnt, 32'd16);
        check("to_release", {21'd0, mrdy, data_oe, err, data_out}, {21'd0, 1'b1, 1'b1, 1'b1, 8'hFF});
        drop_e("to", 1'b1);
        check("to_sticky", {31'd0, err}, 32'd1);
`else
        check("error_tied", {31'd0, err}, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
